fir_filter_param: RTL and testbench
===================================

Name: fir_filter_param

Overview:
Parametrised successor to the fixed 4-tap FIR top level. It is an N-tap, single-multiplier, time-multiplexed FIR with alternating-sign taps, runtime coefficient loading, saturating accumulation, magnitude output and a configurable block-completion pulse. It sits between the sample/coefficient input interface and the output register stage, and drives the same modwait/err status semantics as the previous generation.

Parameters:
NUM_TAPS, 4, number of taps / coefficients (>=2)
DATA_W, 16, sample, coefficient and fir_out width (unsigned)
FRAC_W, 15, coefficient fraction bits; product is right-shifted by FRAC_W (0x8000 = 1.0 at default)
ACC_W, DATA_W+1, signed accumulator width
BLOCK_SAMPLES, 1000, outputs per block_done pulse

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
data_ready  in  1  one-cycle strobe: sample_data valid
sample_data  in  DATA_W  new sample
load_coeff  in  1  one-cycle strobe: fir_coefficient valid
fir_coefficient  in  DATA_W  next coefficient, loaded in index order 0..NUM_TAPS-1
modwait  out  1  high while busy (MAC in progress)
err  out  1  sticky error flag
fir_out  out  DATA_W  magnitude of last result, saturated
out_valid  out  1  one-cycle pulse when fir_out updates
block_done  out  1  one-cycle pulse on every BLOCK_SAMPLES-th out_valid
coeff_valid  out  1  high once a full coefficient set is loaded

Behaviour:
- Reset (any state, incl. mid-MAC): state IDLE; modwait, err, out_valid, block_done, coeff_valid = 0; fir_out = 0; delay line, coefficients, load index, tap index, block count = 0.
- States: IDLE, MAC, OUT.
- IDLE, load_coeff=1: coeff[load_idx] <= fir_coefficient; load_idx++. On write to index NUM_TAPS-1: load_idx wraps to 0, coeff_valid <= 1, block count <= 0. load_coeff outside IDLE is ignored, with no err.
- IDLE, data_ready=1, coeff_valid=1, load_coeff=0: shift the delay line (d[0] <= sample_data, d[i] <= d[i-1]); acc <= 0; tap <= 0; err <= 0; modwait <= 1; go to MAC.
- IDLE, data_ready=1 with coeff_valid=0 or load_coeff=1 in the same cycle: sample dropped; err <= 1. Load has priority.
- data_ready=1 in MAC or OUT: sample dropped; err <= 1; the computation in progress continues.
- MAC, one tap per cycle for NUM_TAPS cycles:
  - term = (d[tap]*coeff[tap]) >> FRAC_W, unsigned 2*DATA_W-bit product.
  - Even tap: acc += term. Odd tap: acc -= term.
  - Sum computed at ACC_W+DATA_W+1 bits. If the result is outside the signed ACC_W range, acc saturates to the max/min and err <= 1.
  - After tap NUM_TAPS-1, go to OUT.
- OUT (one cycle):
  - fir_out <= min(|acc|, 2^DATA_W-1).
  - out_valid <= 1; modwait <= 0; block count++.
  - If count reaches BLOCK_SAMPLES: block_done <= 1 with that out_valid, and count <= 0.
  - Go to IDLE.
- Latency: data_ready edge E0 -> out_valid/fir_out registered at edge E(NUM_TAPS+1). modwait high from E0 to E(NUM_TAPS+1). Throughput is one sample per NUM_TAPS+2 cycles (the next data_ready is accepted in the cycle after out_valid).
- err stays set until the next accepted sample clears it. A dropped sample in the same cycle as an accept cannot occur.

Decomposition:
- Package fir_pkg: state enum (IDLE, MAC, OUT); saturation/magnitude helper functions; localparam for product width 2*DATA_W.
- Sub-module fir_mac_unit: multiply, shift, signed add/sub, saturate, overflow flag. Purely combinational, with the acc register in the top.
- FSM, delay line, coefficient bank and block counter live in the top.

Test Plan:
1. Defaults. Load 4 x 0x8000, then feed samples 100, 200, 300, 400 (wait for out_valid each time) -> fir_out = 100, 100, 200, 200. err = 0. out_valid exactly 5 cycles after each data_ready.
2. Load coeff {0xFFFF, 0, 0, 0}, then sample 0xFFFF -> err = 1, fir_out = 0xFFFF. A next valid sample with coeff reloaded to {0x8000, 0, 0, 0} and sample 5 -> err clears at accept, fir_out = 5.
3. data_ready pulsed 2 cycles after an accepted sample -> err = 1, the in-flight result is still correct, the second sample is never shifted in (next output reflects the old delay line).
4. After reset, data_ready before any load -> err = 1, no out_valid, modwait = 0. Loading 3 of 4 coeffs then data_ready -> still err.
5. BLOCK_SAMPLES=3 override, 7 samples -> block_done coincident with the 3rd and 6th out_valid only. A full coefficient reload after the 4th restarts the count (next block_done on the 7th).
6. Assert reset during the 2nd MAC cycle -> the next cycle has all outputs 0, coeff_valid = 0, no out_valid ever emitted for that sample.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the parametrised time-multiplexed FIR.
// Helpers work on 64-bit signed values so any width up to 62 bits can reuse them.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PROD_W = 2 * DEF_DATA_W;

    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

    // Clamp v into the signed range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    // min(|v|, 2^w - 1)
    function automatic logic signed [63:0] mag_sat(input logic signed [63:0] v,
                                                   input int w);
        logic signed [63:0] a;
        logic signed [63:0] hi;
        a  = (v < 0) ? -v : v;
        hi = (64'sd1 <<< w) - 64'sd1;
        return (a > hi) ? hi : a;
    endfunction

endpackage

// File: rtl/fir_filter_param_mac_unit.sv
// Combinational multiply-shift-accumulate step with saturation to the accumulator range.
// The accumulator register itself lives in the FIR top level.
module fir_mac_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15,
    parameter int ACC_W  = DATA_W + 1
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [DATA_W-1:0] sample,
    input  logic        [DATA_W-1:0] coeff,
    input  logic                     subtract,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic                     ovf
);
    import fir_pkg::*;

    localparam int PROD_W = prod_width(DATA_W);
    localparam int SUM_W  = ACC_W + DATA_W + 1;

    logic        [PROD_W-1:0] prod;
    logic        [SUM_W-1:0]  term;
    logic signed [SUM_W-1:0]  acc_ext;
    logic signed [SUM_W-1:0]  sum;
    logic signed [63:0]       sum_sat;

    always_comb begin
        prod     = PROD_W'(sample) * PROD_W'(coeff);
        term     = SUM_W'(prod >> FRAC_W);
        acc_ext  = SUM_W'(acc);
        // term is far below 2^(SUM_W-1), so reading it as signed keeps it positive
        sum      = subtract ? (acc_ext - signed'(term)) : (acc_ext + signed'(term));
        sum_sat  = sat_signed(64'(sum), ACC_W);
        acc_next = ACC_W'(sum_sat);
        ovf      = (sum_sat != 64'(sum));
    end

endmodule

// File: rtl/fir_filter_param.sv
// N-tap single-multiplier FIR with alternating-sign taps, runtime coefficient loading,
// saturating accumulation, magnitude output and a block-completion pulse.
//
// state | meaning
// IDLE  | waiting for a coefficient write or a sample
// MAC   | one tap per cycle, NUM_TAPS cycles
// OUT   | register |acc| to fir_out, pulse out_valid
module fir_filter_param #(
    parameter int NUM_TAPS      = 4,
    parameter int DATA_W        = 16,
    parameter int FRAC_W        = 15,
    parameter int ACC_W         = DATA_W + 1,
    parameter int BLOCK_SAMPLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              load_coeff,
    input  logic [DATA_W-1:0] fir_coefficient,
    output logic              modwait,
    output logic              err,
    output logic [DATA_W-1:0] fir_out,
    output logic              out_valid,
    output logic              block_done,
    output logic              coeff_valid
);
    import fir_pkg::*;

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(BLOCK_SAMPLES + 1);
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_SAMPLES - 1);

    fir_state_t state_q, state_d;

    logic        [DATA_W-1:0] dly   [NUM_TAPS];
    logic        [DATA_W-1:0] coeff [NUM_TAPS];
    logic        [IDX_W-1:0]  load_idx;
    logic        [IDX_W-1:0]  tap;
    logic        [CNT_W-1:0]  blk_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     mac_ovf;
    logic                     accept;

    // A coefficient write in the same cycle wins over the sample
    assign accept = (state_q == IDLE) && data_ready && coeff_valid && !load_coeff;

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc      (acc),
        .sample   (dly[tap]),
        .coeff    (coeff[tap]),
        .subtract (tap[0]),
        .acc_next (acc_next),
        .ovf      (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (tap == LAST_TAP) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                dly[i]   <= '0;
                coeff[i] <= '0;
            end
            load_idx    <= '0;
            tap         <= '0;
            blk_cnt     <= '0;
            acc         <= '0;
            modwait     <= 1'b0;
            err         <= 1'b0;
            fir_out     <= '0;
            out_valid   <= 1'b0;
            block_done  <= 1'b0;
            coeff_valid <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            block_done <= 1'b0;
            if (data_ready && !accept)
                err <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (load_coeff) begin
                        coeff[load_idx] <= fir_coefficient;
                        if (load_idx == LAST_TAP) begin
                            load_idx    <= '0;
                            coeff_valid <= 1'b1;
                            blk_cnt     <= '0;
                        end else begin
                            load_idx <= load_idx + IDX_W'(1);
                        end
                    end else if (accept) begin
                        dly[0] <= sample_data;
                        for (int i = 1; i < NUM_TAPS; i++)
                            dly[i] <= dly[i-1];
                        acc     <= '0;
                        tap     <= '0;
                        err     <= 1'b0;
                        modwait <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (mac_ovf)
                        err <= 1'b1;
                    if (tap == LAST_TAP)
                        tap <= '0;
                    else
                        tap <= tap + IDX_W'(1);
                end
                OUT: begin
                    fir_out   <= DATA_W'(mag_sat(64'(acc), DATA_W));
                    out_valid <= 1'b1;
                    modwait   <= 1'b0;
                    if (blk_cnt == LAST_CNT) begin
                        block_done <= 1'b1;
                        blk_cnt    <= '0;
                    end else begin
                        blk_cnt <= blk_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed self-checking bench for fir_filter_param: default instance plus a
// BLOCK_SAMPLES=3 instance sharing the same stimulus.
module tb_fir_filter_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_ready;
    logic [15:0] sample_data;
    logic        load_coeff;
    logic [15:0] fir_coefficient;

    logic        modwait, err, out_valid, block_done, coeff_valid;
    logic [15:0] fir_out;
    logic        modwait_b, err_b, out_valid_b, block_done_b, coeff_valid_b;
    logic [15:0] fir_out_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_filter_param dut (
        .clk             (clk),
        .reset           (reset),
        .data_ready      (data_ready),
        .sample_data     (sample_data),
        .load_coeff      (load_coeff),
        .fir_coefficient (fir_coefficient),
        .modwait         (modwait),
        .err             (err),
        .fir_out         (fir_out),
        .out_valid       (out_valid),
        .block_done      (block_done),
        .coeff_valid     (coeff_valid)
    );

    fir_filter_param #(.BLOCK_SAMPLES(3)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .data_ready      (data_ready),
        .sample_data     (sample_data),
        .load_coeff      (load_coeff),
        .fir_coefficient (fir_coefficient),
        .modwait         (modwait_b),
        .err             (err_b),
        .fir_out         (fir_out_b),
        .out_valid       (out_valid_b),
        .block_done      (block_done_b),
        .coeff_valid     (coeff_valid_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; data_ready = 1'b0; load_coeff = 1'b0;
        sample_data = '0; fir_coefficient = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load4(input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] c2, input logic [15:0] c3);
        logic [15:0] cs [4];
        cs = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            load_coeff = 1'b1;
            fir_coefficient = cs[i];
            tick();
        end
        load_coeff = 1'b0;
    endtask

    task automatic send(input logic [15:0] s);
        data_ready = 1'b1;
        sample_data = s;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic idle_cycles(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            tick();
            if (out_valid) seen++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fir_out !== 16'h0) begin
            failures++; $display("FAIL reset_fir_out got=%0h want=0", fir_out);
        end
        checks++;
        if ({modwait, err, out_valid, block_done, coeff_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {modwait, err, out_valid, block_done, coeff_valid});
        end
    endtask

    task automatic test_defaults();
        logic [15:0] s   [4];
        logic [15:0] exp [4];
        int lat;
        s   = '{16'd100, 16'd200, 16'd300, 16'd400};
        exp = '{16'd100, 16'd100, 16'd200, 16'd200};
        load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        checks++;
        if (coeff_valid !== 1'b1) begin
            failures++; $display("FAIL defaults_coeff_valid got=%b want=1", coeff_valid);
        end
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            checks++;
            if (modwait !== 1'b1) begin
                failures++; $display("FAIL defaults_modwait[%0d] got=%b want=1", i, modwait);
            end
            wait_out(lat);
            checks++;
            if (lat != 5) begin
                failures++; $display("FAIL defaults_latency[%0d] got=%0d want=5", i, lat);
            end
            checks++;
            if (fir_out !== exp[i]) begin
                failures++; $display("FAIL defaults_fir_out[%0d] got=%0d want=%0d", i, fir_out, exp[i]);
            end
            checks++;
            if (err !== 1'b0 || modwait !== 1'b0) begin
                failures++; $display("FAIL defaults_err_modwait[%0d] got=%b%b want=00", i, err, modwait);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        load4(16'hFFFF, 16'h0, 16'h0, 16'h0);
        send(16'hFFFF);
        wait_out(lat);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL sat_err got=%b want=1", err);
        end
        checks++;
        if (fir_out !== 16'hFFFF) begin
            failures++; $display("FAIL sat_fir_out got=%0h want=ffff", fir_out);
        end
        load4(16'h8000, 16'h0, 16'h0, 16'h0);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL sat_err_sticky got=%b want=1", err);
        end
        send(16'd5);
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL sat_err_clear got=%b want=0", err);
        end
        wait_out(lat);
        checks++;
        if (fir_out !== 16'd5 || lat != 5) begin
            failures++; $display("FAIL sat_recover got=%0d lat=%0d want=5 lat=5", fir_out, lat);
        end
    endtask

    task automatic test_drop_in_flight();
        int lat;
        do_reset();
        load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        send(16'd10);
        tick();
        send(16'd999);
        checks++;
        if (err !== 1'b1 || modwait !== 1'b1) begin
            failures++; $display("FAIL drop_err_modwait got=%b%b want=11", err, modwait);
        end
        wait_out(lat);
        checks++;
        if (fir_out !== 16'd10 || lat != 3) begin
            failures++; $display("FAIL drop_inflight got=%0d lat=%0d want=10 lat=3", fir_out, lat);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL drop_err_held got=%b want=1", err);
        end
        send(16'd30);
        wait_out(lat);
        checks++;
        if (fir_out !== 16'd20 || err !== 1'b0) begin
            failures++; $display("FAIL drop_not_shifted got=%0d err=%b want=20 err=0", fir_out, err);
        end
    endtask

    task automatic test_not_loaded();
        int seen;
        do_reset();
        send(16'd50);
        checks++;
        if (err !== 1'b1 || modwait !== 1'b0) begin
            failures++; $display("FAIL noload_err_modwait got=%b%b want=10", err, modwait);
        end
        idle_cycles(8, seen);
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL noload_out_valid got=%0d want=0", seen);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load_coeff = 1'b1;
            fir_coefficient = 16'h8000;
            tick();
        end
        load_coeff = 1'b0;
        checks++;
        if (coeff_valid !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL partial_load got=%b%b want=00", coeff_valid, err);
        end
        send(16'd50);
        idle_cycles(8, seen);
        checks++;
        if (err !== 1'b1 || seen != 0) begin
            failures++; $display("FAIL partial_drop got err=%b outs=%0d want err=1 outs=0", err, seen);
        end
        load_coeff = 1'b1; fir_coefficient = 16'h8000;
        data_ready = 1'b1; sample_data = 16'd60;
        tick();
        load_coeff = 1'b0; data_ready = 1'b0;
        checks++;
        if (coeff_valid !== 1'b1 || err !== 1'b1 || modwait !== 1'b0) begin
            failures++;
            $display("FAIL load_priority got=%b%b%b want=110", coeff_valid, err, modwait);
        end
    endtask

    task automatic test_block_done();
        logic ea [7];
        logic eb [7];
        int lat;
        ea = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        eb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        for (int k = 0; k < 7; k++) begin
            send(16'(k + 1));
            wait_out(lat);
            checks++;
            if (out_valid_b !== 1'b1 || block_done_b !== ea[k] || block_done !== 1'b0) begin
                failures++;
                $display("FAIL block_a[%0d] got v=%b bd3=%b bd=%b want v=1 bd3=%b bd=0",
                         k, out_valid_b, block_done_b, block_done, ea[k]);
            end
        end
        checks++;
        if (fir_out_b !== 16'd2 || err_b !== 1'b0 || modwait_b !== 1'b0 || coeff_valid_b !== 1'b1) begin
            failures++;
            $display("FAIL block_b_state got out=%0d err=%b mw=%b cv=%b want out=2 err=0 mw=0 cv=1",
                     fir_out_b, err_b, modwait_b, coeff_valid_b);
        end
        do_reset();
        load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        for (int k = 0; k < 7; k++) begin
            if (k == 4) load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
            send(16'(k + 1));
            wait_out(lat);
            checks++;
            if (out_valid_b !== 1'b1 || block_done_b !== eb[k]) begin
                failures++;
                $display("FAIL block_reload[%0d] got v=%b bd3=%b want v=1 bd3=%b",
                         k, out_valid_b, block_done_b, eb[k]);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int seen;
        do_reset();
        load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        send(16'd7);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({modwait, err, out_valid, block_done, coeff_valid} !== 5'b0 || fir_out !== 16'h0) begin
            failures++;
            $display("FAIL midmac_reset got flags=%b out=%0h want flags=00000 out=0",
                     {modwait, err, out_valid, block_done, coeff_valid}, fir_out);
        end
        reset = 1'b0;
        idle_cycles(10, seen);
        checks++;
        if (seen != 0 || modwait !== 1'b0) begin
            failures++; $display("FAIL midmac_no_output got outs=%0d mw=%b want outs=0 mw=0", seen, modwait);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_saturation();
        test_drop_in_flight();
        test_not_loaded();
        test_block_done();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
